// File: rtl/n64adv_osd_pkg.sv
// Shared types, default widths and {ctrl,addr,data} word slicing helpers for the OSD write path.
// The slicing macros expect CTRL_W, ADDR_W and DATA_W to be visible where they are used.
`define OSD_WORD_CTRL(w) w[CTRL_W+ADDR_W+DATA_W-1 -: CTRL_W]
`define OSD_WORD_ADDR(w) w[ADDR_W+DATA_W-1 -: ADDR_W]
`define OSD_WORD_DATA(w) w[DATA_W-1:0]

package n64adv_osd_pkg;

  localparam int OSD_CTRL_W     = 2;
  localparam int OSD_ADDR_W     = 10;
  localparam int OSD_DATA_W     = 13;
  localparam int OSD_LOCK_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/osd_wr_fifo.sv
// Single-clock synchronous FIFO with synchronous clear; one instance per requester.
// A push is taken when full only if a pop frees the slot in the same cycle.
module osd_wr_fifo #(
  parameter int AW = 2,
  parameter int W  = 25
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH[AW:0]);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every variable gets its default before any branch, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments so all flops sample the pre-edge values together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push && !clr) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/osd_wr_arbiter.sv
// Round-robin arbiter sharing the OSD RAM write port between the NIOS vector and the status overlay.
// Define OSD_WR_VSYNC_GATE_EN to restrict pops (and lock counting) to the osd_blank window.
module osd_wr_arbiter
  import n64adv_osd_pkg::*;
#(
  parameter int FIFO_AW  = 2,
  parameter int CTRL_W   = OSD_CTRL_W,
  parameter int ADDR_W   = OSD_ADDR_W,
  parameter int DATA_W   = OSD_DATA_W,
  parameter int LOCK_MAX = 255
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             flush,
  input  logic                             osd_blank,
  input  logic                             req0_valid,
  output logic                             req0_ready,
  input  logic                             req0_lock,
  input  logic [CTRL_W+ADDR_W+DATA_W-1:0] req0_word,
  input  logic                             req1_valid,
  output logic                             req1_ready,
  input  logic [CTRL_W+ADDR_W+DATA_W-1:0] req1_word,
  output logic                             wr_en,
  output logic [CTRL_W-1:0]                wr_ctrl,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  output logic                             wr_src,
  output logic                             lock_timeout,
  output logic [FIFO_AW:0]                 pend0,
  output logic [FIFO_AW:0]                 pend1
);

  localparam int WORD_W = CTRL_W + ADDR_W + DATA_W;
  localparam logic [OSD_LOCK_CNT_W-1:0] LOCK_MAX_C = OSD_LOCK_CNT_W'(LOCK_MAX);

  arb_state_e                state_q, state_d;
  logic [OSD_LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic                      rr_q, rr_d;
  logic                      lock_timeout_q, lock_timeout_d;
  logic                      lock_block_q, lock_block_d;
  logic                      wr_en_q, wr_en_d;
  logic                      wr_src_q, wr_src_d;
  logic [WORD_W-1:0]         wr_word_q, wr_word_d;

  logic              full0, empty0, full1, empty1;
  logic              push0, push1, pop0, pop1;
  logic [WORD_W-1:0] rdata0, rdata1;
  logic              blank_ok;

`ifdef OSD_WR_VSYNC_GATE_EN
  assign blank_ok = osd_blank;
`else
  logic unused_blank;
  assign unused_blank = osd_blank;
  assign blank_ok     = 1'b1;
`endif

  assign req0_ready = ~full0 & ~flush;
  assign req1_ready = ~full1 & ~flush;
  assign push0      = req0_valid & req0_ready;
  assign push1      = req1_valid & req1_ready;

  osd_wr_fifo #(.AW(FIFO_AW), .W(WORD_W)) u_fifo0 (
    .CLK(CLK), .RST(RST), .clr(flush), .push(push0), .pop(pop0), .wdata(req0_word),
    .rdata(rdata0), .full(full0), .empty(empty0), .count(pend0)
  );

  osd_wr_fifo #(.AW(FIFO_AW), .W(WORD_W)) u_fifo1 (
    .CLK(CLK), .RST(RST), .clr(flush), .push(push1), .pop(pop1), .wdata(req1_word),
    .rdata(rdata1), .full(full1), .empty(empty1), .count(pend1)
  );

  assign lock_cnt_inc = lock_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    rr_d           = rr_q;
    lock_timeout_d = lock_timeout_q;
    lock_block_d   = lock_block_q;
    pop0           = 1'b0;
    pop1           = 1'b0;

    // A forced release stays armed until requester 0 drops its lock for a cycle.
    if (lock_block_q && !req0_lock) lock_block_d = 1'b0;

    if (flush) begin
      state_d        = ST_IDLE;
      lock_cnt_d     = '0;
      lock_timeout_d = 1'b0;
      lock_block_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blank_ok) begin
            if (!empty0 && !empty1) begin
              pop0 = ~rr_q;
              pop1 = rr_q;
              rr_d = ~rr_q;
            end else if (!empty0) begin
              pop0 = 1'b1;
              rr_d = 1'b0;
            end else if (!empty1) begin
              pop1 = 1'b1;
              rr_d = 1'b1;
            end
          end
          if (req0_lock && !lock_block_q) begin
            state_d    = ST_LOCK;
            lock_cnt_d = '0;
          end
        end
        ST_LOCK: begin
          if (blank_ok && !empty0) begin
            pop0 = 1'b1;
            rr_d = 1'b0;
          end
          if (blank_ok) lock_cnt_d = lock_cnt_inc;
          if (!req0_lock) begin
            state_d = ST_IDLE;
          end else if (blank_ok && lock_cnt_inc == LOCK_MAX_C) begin
            state_d        = ST_IDLE;
            lock_timeout_d = 1'b1;
            lock_block_d   = 1'b1;
            rr_d           = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    wr_en_d   = pop0 | pop1;
    wr_src_d  = pop1 ? 1'b1 : (pop0 ? 1'b0 : wr_src_q);
    wr_word_d = pop1 ? rdata1 : (pop0 ? rdata0 : wr_word_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      lock_cnt_q     <= '0;
      rr_q           <= 1'b0;
      lock_timeout_q <= 1'b0;
      lock_block_q   <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_src_q       <= 1'b0;
      wr_word_q      <= '0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      rr_q           <= rr_d;
      lock_timeout_q <= lock_timeout_d;
      lock_block_q   <= lock_block_d;
      wr_en_q        <= wr_en_d;
      wr_src_q       <= wr_src_d;
      wr_word_q      <= wr_word_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_src       = wr_src_q;
  assign wr_ctrl      = `OSD_WORD_CTRL(wr_word_q);
  assign wr_addr      = `OSD_WORD_ADDR(wr_word_q);
  assign wr_data      = `OSD_WORD_DATA(wr_word_q);
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Scoreboard bench for osd_wr_arbiter: stimulus queues expected writes, a negedge monitor checks them.
// The osd_blank gating scenario runs only when OSD_WR_VSYNC_GATE_EN is defined.
module tb_osd_wr_arbiter;

  localparam int WORD_W   = 25;
  localparam int LOCK_MAX = 255;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              flush = 1'b0;
  logic              osd_blank = 1'b1;
  logic              req0_valid = 1'b0;
  logic              req0_lock = 1'b0;
  logic              req1_valid = 1'b0;
  logic [WORD_W-1:0] req0_word = '0;
  logic [WORD_W-1:0] req1_word = '0;

  logic        req0_ready, req1_ready, wr_en, wr_src, lock_timeout;
  logic [1:0]  wr_ctrl;
  logic [9:0]  wr_addr;
  logic [12:0] wr_data;
  logic [2:0]  pend0, pend1;

  osd_wr_arbiter dut (
    .CLK(CLK), .RST(RST), .flush(flush), .osd_blank(osd_blank),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock), .req0_word(req0_word),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_word(req1_word),
    .wr_en(wr_en), .wr_ctrl(wr_ctrl), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src),
    .lock_timeout(lock_timeout), .pend0(pend0), .pend1(pend1)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic              src;
    logic [WORD_W-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk(input logic [1:0] c, input logic [9:0] a, input logic [12:0] d);
    return {c, a, d};
  endfunction

  task automatic expect_wr(input logic src, input logic [WORD_W-1:0] word);
    exp_t e;
    e.src  = src;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", wr_en, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_src", wr_src, e.src);
          check("wr_word", {wr_ctrl, wr_addr, wr_data}, e.word);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] s0 [4];
    logic [WORD_W-1:0] s1 [4];
    logic [WORD_W-1:0] f  [5];
    logic [9:0]        seen;
    logic              rdy_ok, acc;
    int                k, nwr;

    // Reset state
    #5;
    check("rst_wr_en", wr_en, 0);
    check("rst_pend0", pend0, 0);
    check("rst_pend1", pend1, 0);
    check("rst_lock_timeout", lock_timeout, 0);
    check("rst_wr_fields", {wr_src, wr_ctrl, wr_addr, wr_data}, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Single word via requester 0: strobe two cycles after the push
    w = mk(2'b01, 10'h025, 13'h0041);
    expect_wr(1'b0, w);
    req0_word  = w;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    @(negedge CLK);
    check("t1_pend0_queued", pend0, 1);
    check("t1_no_early_wr", wr_en, 0);
    step();
    @(negedge CLK);
    check("t1_wr_en_cycle2", wr_en, 1);
    check("t1_pend0_empty", pend0, 0);
    step();
    @(negedge CLK);
    check("t1_wr_en_pulse", wr_en, 0);
    check("t1_wr_addr_hold", wr_addr, 10'h025);
    step();

    // Simultaneous streams: pointer sits at 0, so writes go 0,1,0,1,...
    for (int i = 0; i < 4; i++) begin
      s0[i] = mk(2'b10, 10'(256 + i), 13'(2560 + i));
      s1[i] = mk(2'b11, 10'(512 + i), 13'(6912 + i));
      expect_wr(1'b0, s0[i]);
      expect_wr(1'b1, s1[i]);
    end
    rdy_ok = 1'b1;
    seen   = '0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      if (i < 4) begin
        req0_word = s0[i];
        req1_word = s1[i];
      end
      @(negedge CLK);
      seen[i] = wr_en;
      if (i < 4) rdy_ok = rdy_ok & req0_ready & req1_ready;
      step();
    end
    check("t2_ready_held", rdy_ok, 1);
    check("t2_write_cycles", seen, 10'b11_1111_1100);
    wait_drain("t2", 5);

    // Full boundary on requester 1 while requester 0 holds the lock with an empty FIFO
    for (int i = 0; i < 5; i++) f[i] = mk(2'(i), 10'(768 + i), 13'(4096 + i));
    req0_lock = 1'b1;
    step();
    rdy_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_word  = f[i];
      req1_valid = 1'b1;
      expect_wr(1'b1, f[i]);
      @(negedge CLK);
      rdy_ok = rdy_ok & req1_ready;
      step();
    end
    req1_word = f[4];
    @(negedge CLK);
    check("t3_ready_before_full", rdy_ok, 1);
    check("t3_ready_when_full", req1_ready, 0);
    check("t3_pend1_full", pend1, 4);
    repeat (3) step();
    @(negedge CLK);
    check("t3_pend1_held", pend1, 4);
    check("t3_no_wr_in_lock", wr_en, 0);
    expect_wr(1'b1, f[4]);
    step();
    req0_lock = 1'b0;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      @(negedge CLK);
      if (req1_ready) acc = 1'b1;
      step();
    end
    req1_valid = 1'b0;
    check("t3_fifth_accepted", acc, 1);
    wait_drain("t3", 20);

    // Lock timeout: lock entered at E0, timeout visible LOCK_MAX edges later, then a src-1 write
    req0_lock = 1'b1;
    step();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      w          = mk(2'b01, 10'(64 + i), 13'(32 + i));
      req1_word  = w;
      req1_valid = 1'b1;
      expect_wr(1'b1, w);
      step();
      k++;
    end
    req1_valid = 1'b0;
    @(negedge CLK);
    while (!lock_timeout && k < 400) begin
      step();
      k++;
      @(negedge CLK);
    end
    check("t4_timeout_cycle", k, LOCK_MAX);
    step();
    @(negedge CLK);
    check("t4_next_wr_src1", {wr_en, wr_src}, 2'b11);
    repeat (40) step();
    @(negedge CLK);
    check("t4_drained_while_locked", pend1, 0);
    step();
    wait_drain("t4", 5);
    req0_lock = 1'b0;
    step();
    @(negedge CLK);
    check("t4_timeout_sticky", lock_timeout, 1);
    step();

    // Flush mid-stream: the timeout left the pointer at 1, so requester 1 wins the first tie
    for (int i = 0; i < 4; i++) begin
      s0[i] = mk(2'b00, 10'(128 + i), 13'(16 + i));
      s1[i] = mk(2'b11, 10'(896 + i), 13'(8000 + i));
    end
    expect_wr(1'b1, s1[0]);
    expect_wr(1'b0, s0[0]);
    for (int i = 0; i < 3; i++) begin
      req0_word  = s0[i];
      req1_word  = s1[i];
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
    end
    req0_word = s0[3];
    req1_word = s1[3];
    flush     = 1'b1;
    @(negedge CLK);
    check("t5_ready0_flush", req0_ready, 0);
    check("t5_ready1_flush", req1_ready, 0);
    check("t5_pend0_before", pend0, 2);
    check("t5_pend1_before", pend1, 2);
    step();
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    check("t5_pend0_after", pend0, 0);
    check("t5_pend1_after", pend1, 0);
    check("t5_lock_timeout_clr", lock_timeout, 0);
    check("t5_no_wr_after_flush", wr_en, 0);
    nwr = 0;
    repeat (10) begin
      step();
      @(negedge CLK);
      if (wr_en) nwr++;
    end
    check("t5_quiet", nwr, 0);
    check("t5_queue_empty", exp_q.size(), 0);
    step();

`ifdef OSD_WR_VSYNC_GATE_EN
    // Blank gating: words wait outside blank, then drain on the first two blank cycles
    osd_blank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s0[i]      = mk(2'b10, 10'(32 + i), 13'(100 + i));
      req0_word  = s0[i];
      req0_valid = 1'b1;
      step();
    end
    req0_valid = 1'b0;
    nwr = 0;
    repeat (100) begin
      @(negedge CLK);
      if (wr_en) nwr++;
      step();
    end
    @(negedge CLK);
    check("gate_no_wr", nwr, 0);
    check("gate_pend0", pend0, 2);
    expect_wr(1'b0, s0[0]);
    expect_wr(1'b0, s0[1]);
    step();
    osd_blank = 1'b1;
    step();
    @(negedge CLK);
    check("gate_wr_first", wr_en, 1);
    step();
    @(negedge CLK);
    check("gate_wr_second", wr_en, 1);
    step();
    wait_drain("gate", 5);
`endif

    // Asynchronous reset while a write strobe is high
    w = mk(2'b00, 10'h3FF, 13'h1FFF);
    expect_wr(1'b0, w);
    req0_word  = w;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    @(negedge CLK);
    check("rst_mid_wr_en_high", wr_en, 1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_wr_en", wr_en, 0);
    check("rst_async_pend0", pend0, 0);
    check("rst_async_fields", {wr_src, wr_ctrl, wr_addr, wr_data}, 0);
    step();
    RST = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
